// File: rtl/uart_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver_if
//  Description : Bundle of the UART receive path signals: serial line and
//                oversample tick in, received byte, strobes and busy out.
//                The receiver uses the slave modport; the driver of the line
//                and consumer of the byte uses the master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_receiver_if #(
    parameter int BITS = 8
);
    logic            i_RX;
    logic            i_TICK;
    logic [BITS-1:0] o_RX_DATA;
    logic            o_RX_DV;
    logic            o_RX_FRAME_ERR;
    logic            o_RX_PARITY_ERR;
    logic            o_RX_BUSY;

    modport slave (
        input  i_RX,
        input  i_TICK,
        output o_RX_DATA,
        output o_RX_DV,
        output o_RX_FRAME_ERR,
        output o_RX_PARITY_ERR,
        output o_RX_BUSY
    );

    modport master (
        output i_RX,
        output i_TICK,
        input  o_RX_DATA,
        input  o_RX_DV,
        input  o_RX_FRAME_ERR,
        input  o_RX_PARITY_ERR,
        input  o_RX_BUSY
    );
endinterface
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : UART receive path. Synchronizes the serial line, detects
//                the start bit, samples every bit at mid-bit using the shared
//                oversample tick, assembles the byte LSB first, checks the
//                stop bit and reports the byte with a one-cycle valid strobe.
//                Optional parity checking is enabled by defining the macro
//                UART_RX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int OVERSAMPLE_RATE = 16,
    parameter int BITS            = 8,
    parameter int PARITY_ODD      = 0
) (
    input  wire logic        P_CLK,
    input  wire logic        reset,
    uart_receiver_if.slave   rx_if
);

    localparam int TW = $clog2(OVERSAMPLE_RATE);
    localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;

    localparam logic [TW-1:0] c_TICK_HALF = TW'(OVERSAMPLE_RATE / 2 - 1);
    localparam logic [TW-1:0] c_TICK_LAST = TW'(OVERSAMPLE_RATE - 1);
    localparam logic [BW-1:0] c_BIT_LAST  = BW'(BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    logic            sync1_q;
    logic            rx_s_q;
    state_t          state_q,    state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [BITS-1:0] shift_q,    shift_d;
    logic [BITS-1:0] data_q,     data_d;
    logic            dv_q,       dv_d;
    logic            ferr_q,     ferr_d;
    logic            w_tick_done;
    logic [BITS:0]   w_shift_ext;
`ifdef UART_RX_PARITY_EN
    logic            parity_q,   parity_d;
    logic            perr_q,     perr_d;
    logic            w_parity_exp;
`else
    logic            w_unused_parity_odd;
`endif

    assign w_tick_done = (tick_cnt_q == c_TICK_LAST);
    // Shift right: the newly sampled bit enters at the MSB, so after BITS
    // samples the first (LSB) bit has reached position 0.
    assign w_shift_ext = {rx_s_q, shift_q};

    // Two-flop synchronizer on the asynchronous serial line, idle high.
    always_ff @(posedge P_CLK or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_if.i_RX;
            rx_s_q  <= sync1_q;
        end
    end

    // State, counters, shift register and output strobes.
    always_ff @(posedge P_CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            dv_q       <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q   <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            dv_q       <= dv_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            parity_q   <= parity_d;
            perr_q     <= perr_d;
`endif
        end
    end

`ifdef UART_RX_PARITY_EN
    assign w_parity_exp = (^shift_q) ^ (PARITY_ODD != 0);
`endif

    // Next-state logic; everything advances only on oversample ticks.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        dv_d       = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_d   = parity_q;
        perr_d     = 1'b0;
`endif
        if (rx_if.i_TICK) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                    end
                end
                S_START: begin
                    // Re-check the line at the middle of the start bit so a
                    // short low glitch is not taken as a frame.
                    if (tick_cnt_q == c_TICK_HALF) begin
                        tick_cnt_d = '0;
                        if (!rx_s_q) begin
                            state_d   = S_DATA;
                            bit_cnt_d = '0;
                        end else begin
                            state_d   = S_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tick_done) begin
                        tick_cnt_d = '0;
                        shift_d    = w_shift_ext[BITS:1];
                        if (bit_cnt_q == c_BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_tick_done) begin
                        tick_cnt_d = '0;
                        parity_d   = rx_s_q;
                        state_d    = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick_done) begin
                        tick_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        perr_d     = (parity_q != w_parity_exp);
`endif
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            dv_d    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    // A held-low line must return high before a new frame.
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    tick_cnt_d = '0;
                end
            endcase
        end
    end

    assign rx_if.o_RX_DATA      = data_q;
    assign rx_if.o_RX_DV        = dv_q;
    assign rx_if.o_RX_FRAME_ERR = ferr_q;
    assign rx_if.o_RX_BUSY      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_if.o_RX_PARITY_ERR = perr_q;
`else
    assign rx_if.o_RX_PARITY_ERR = 1'b0;
    assign w_unused_parity_odd   = (PARITY_ODD != 0);
`endif

endmodule
`default_nettype wire
